// File: rtl/mmio_input_ctrl.sv
// Memory-mapped debounced push-button/switch input block: LEVEL (RO) and sticky W1C EDGE registers.
// Define MMIO_INPUT_FALL_EDGE_EN to add a sticky W1C FALL register at BASE_ADDR+8.
module mmio_input_ctrl #(
    parameter int WIDTH           = 16,
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BASE_ADDR       = 6024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons,
    input  logic [WIDTH-1:0]     addr,
    input  logic                 rd,
    input  logic                 we,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 hit,
    output logic                 irq
);

    localparam int                CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]     CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0]  ADDR_LEVEL = WIDTH'(BASE_ADDR);
    localparam logic [WIDTH-1:0]  ADDR_EDGE  = WIDTH'(BASE_ADDR + 4);

    logic [N_BUTTONS-1:0] r_sync1;
    logic [N_BUTTONS-1:0] r_sync2;
    logic [N_BUTTONS-1:0] r_level;
    logic [CW-1:0]        r_cnt [N_BUTTONS];
    logic [WIDTH-1:0]     r_edge;
    logic [WIDTH-1:0]     r_rdata;
    logic                 r_hit;
    logic                 r_irq;

    logic [N_BUTTONS-1:0] w_accept;
    logic                 w_sel_level;
    logic                 w_sel_edge;
    logic                 w_sel_fall;
    logic                 w_mapped;
    logic [WIDTH-1:0]     w_edge_clr;
    logic [WIDTH-1:0]     w_rd_val;
    logic                 w_irq_src;

    // A channel accepts its new level on the cycle its count would reach DEBOUNCE_CYCLES.
    always_comb begin
        w_accept = '0;
        for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            w_accept[i] = (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            for (int unsigned i = 0; i < N_BUTTONS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < N_BUTTONS; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_sel_level = (addr == ADDR_LEVEL);
    assign w_sel_edge  = (addr == ADDR_EDGE);
    assign w_mapped    = w_sel_level | w_sel_edge | w_sel_fall;
    assign w_edge_clr  = (we && w_sel_edge) ? wdata : '0;

    // Flag registers are WIDTH wide; bits at or above N_BUTTONS are never set and stay 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | WIDTH'(w_accept & r_sync2);
        end
    end

`ifdef MMIO_INPUT_FALL_EDGE_EN
    localparam logic [WIDTH-1:0] ADDR_FALL = WIDTH'(BASE_ADDR + 8);

    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] w_fall_clr;

    assign w_sel_fall = (addr == ADDR_FALL);
    assign w_fall_clr = (we && w_sel_fall) ? wdata : '0;
    assign w_irq_src  = |{r_edge, r_fall};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fall <= '0;
        end else begin
            r_fall <= (r_fall & ~w_fall_clr) | WIDTH'(w_accept & ~r_sync2);
        end
    end
`else
    assign w_sel_fall = 1'b0;
    assign w_irq_src  = |r_edge;
`endif

    always_comb begin
        w_rd_val = '0;
        if (w_sel_level) begin
            w_rd_val = WIDTH'(r_level);
        end else if (w_sel_edge) begin
            w_rd_val = r_edge;
        end
`ifdef MMIO_INPUT_FALL_EDGE_EN
        else if (w_sel_fall) begin
            w_rd_val = r_fall;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (rd) begin
                r_rdata <= w_rd_val;
            end
            r_hit <= (rd | we) & w_mapped;
            r_irq <= w_irq_src;
        end
    end

    assign rdata = r_rdata;
    assign hit   = r_hit;
    assign irq   = r_irq;

endmodule
